// File: rtl/trace_filter_if.sv
// rtl/trace_filter_if.sv - retired-instruction input and forwarded-item output bundle
interface trace_filter_if #(
  parameter int XLEN = 64
);
  logic            in_valid;
  logic [XLEN-1:0] in_pc;
  logic [31:0]     in_instr;
  logic            out_valid;
  logic [XLEN-1:0] out_pc;
  logic [31:0]     out_instr;
  logic [2:0]      out_reason;

  modport master (
    output in_valid, in_pc, in_instr,
    input  out_valid, out_pc, out_instr, out_reason
  );

  modport slave (
    input  in_valid, in_pc, in_instr,
    output out_valid, out_pc, out_instr, out_reason
  );
endinterface

// File: rtl/trace_filter.sv
// rtl/trace_filter.sv - keeps only the retired instructions needed to rebuild control flow
module trace_filter #(
  parameter int XLEN = 64,
  parameter int RESYNC_TIMER_WIDTH = 8,
  parameter logic [RESYNC_TIMER_WIDTH-1:0] RESYNC_TIMER_RESET_VALUE = 8'd10
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  input  logic                 enable,
  trace_filter_if.slave        tr,
  output logic [31:0]          dropped_count
);

  typedef enum logic [1:0] {IDLE, SYNC, RUN} state_t;

  state_t                        state, state_next;
  logic [RESYNC_TIMER_WIDTH-1:0] timer, timer_next;
  logic                          need_dest, need_dest_next;
  logic                          fwd, drop, cf, expired;
  logic [2:0]                    reason;

  function automatic logic is_cf(input logic [31:0] i);
    logic c32, cb, cj, cjr;
    c32 = (i[1:0] == 2'b11) &&
          ((i[6:0] == 7'b1100011) || (i[6:0] == 7'b1101111) || (i[6:0] == 7'b1100111));
    cb  = (i[1:0] == 2'b01) && (i[15:14] == 2'b11);
    cj  = (i[1:0] == 2'b01) && (i[15:13] == 3'b101);
    // rs1 must be nonzero and rs2 zero, which excludes c.mv/c.add/c.ebreak
    cjr = (i[1:0] == 2'b10) && (i[15:13] == 3'b100) && (i[11:7] != 5'd0) && (i[6:2] == 5'd0);
    return c32 | cb | cj | cjr;
  endfunction

  assign cf      = is_cf(tr.in_instr);
  assign expired = (timer == '0);

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state         <= IDLE;
      timer         <= RESYNC_TIMER_RESET_VALUE;
      need_dest     <= 1'b0;
      tr.out_valid  <= 1'b0;
      tr.out_pc     <= '0;
      tr.out_instr  <= '0;
      tr.out_reason <= '0;
      dropped_count <= '0;
    end else begin
      state        <= state_next;
      timer        <= timer_next;
      need_dest    <= need_dest_next;
      tr.out_valid <= fwd;
      if (fwd) begin
        tr.out_pc     <= tr.in_pc;
        tr.out_instr  <= tr.in_instr;
        tr.out_reason <= reason;
      end
      if (drop && (dropped_count != 32'hFFFF_FFFF))
        dropped_count <= dropped_count + 32'd1;
    end
  end

  always_comb begin
    state_next = state;
    if (!enable) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE:    state_next = SYNC;
        SYNC:    if (tr.in_valid) state_next = RUN;
        RUN:     state_next = RUN;
        default: state_next = IDLE;
      endcase
    end
  end

  always_comb begin
    fwd            = 1'b0;
    drop           = 1'b0;
    reason         = 3'b000;
    timer_next     = timer;
    need_dest_next = need_dest;
    if (!enable || (state == IDLE)) begin
      timer_next     = RESYNC_TIMER_RESET_VALUE;
      need_dest_next = 1'b0;
    end else if (tr.in_valid) begin
      if (state == SYNC) begin
        fwd            = 1'b1;
        reason         = {1'b1, 1'b0, cf};
        timer_next     = RESYNC_TIMER_RESET_VALUE;
        need_dest_next = cf;
      end else begin
        fwd            = cf | need_dest | expired;
        reason         = {expired, need_dest, cf};
        need_dest_next = cf;
        if (fwd) begin
          timer_next = RESYNC_TIMER_RESET_VALUE;
        end else begin
          timer_next = timer - 1'b1;
          drop       = 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_trace_filter.sv
// tb/tb_trace_filter.sv - directed checks of forwarding, reasons, resync timer and reset
module tb_trace_filter;

  localparam logic [31:0] ADDI = 32'h0000_0013;
  localparam logic [31:0] BEQ  = 32'h0000_0063;
  localparam logic [31:0] JAL  = 32'h0000_006F;
  localparam logic [31:0] JALR = 32'h0000_8067;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic [31:0] dropped;
  int          n_cmp = 0;
  int          n_err = 0;

  trace_filter_if #(.XLEN(64)) bus ();

  trace_filter #(
    .XLEN(64),
    .RESYNC_TIMER_WIDTH(8),
    .RESYNC_TIMER_RESET_VALUE(8'd10)
  ) dut (
    .CLK(clk),
    .RST_N(rst_n),
    .enable(en),
    .tr(bus),
    .dropped_count(dropped)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic v, input logic [63:0] pc, input logic [31:0] instr);
    bus.in_valid = v;
    bus.in_pc    = pc;
    bus.in_instr = instr;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_fwd(input string tag, input logic [63:0] pc, input logic [31:0] instr,
                         input logic [2:0] reason);
    chk({tag, ".valid"}, {63'd0, bus.out_valid}, 64'd1);
    chk({tag, ".pc"}, bus.out_pc, pc);
    chk({tag, ".instr"}, {32'd0, bus.out_instr}, {32'd0, instr});
    chk({tag, ".reason"}, {61'd0, bus.out_reason}, {61'd0, reason});
  endtask

  task automatic chk_drop(input string tag);
    chk({tag, ".valid"}, {63'd0, bus.out_valid}, 64'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    en    = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_pc    = '0;
    bus.in_instr = '0;
    step(1'b0, 64'd0, 32'd0);
    step(1'b0, 64'd0, 32'd0);
    chk("rst.valid", {63'd0, bus.out_valid}, 64'd0);
    chk("rst.pc", bus.out_pc, 64'd0);
    chk("rst.instr", {32'd0, bus.out_instr}, 64'd0);
    chk("rst.reason", {61'd0, bus.out_reason}, 64'd0);
    chk("rst.dropped", {32'd0, dropped}, 64'd0);

    // first edge after reset moves IDLE -> SYNC
    rst_n = 1'b1;
    step(1'b0, 64'd0, 32'd0);
    chk_drop("idle");

    step(1'b1, 64'h8000_0000, ADDI);
    chk_fwd("sync", 64'h8000_0000, ADDI, 3'b100);
    step(1'b1, 64'h8000_0004, ADDI);
    chk_drop("drop1");
    chk("hold.pc", bus.out_pc, 64'h8000_0000);
    step(1'b1, 64'h8000_0008, ADDI);
    chk_drop("drop2");
    chk("dropped2", {32'd0, dropped}, 64'd2);

    step(1'b1, 64'h1000, BEQ);
    chk_fwd("beq", 64'h1000, BEQ, 3'b001);
    step(1'b1, 64'h2000, ADDI);
    chk_fwd("dest", 64'h2000, ADDI, 3'b010);
    step(1'b1, 64'h2004, ADDI);
    chk_drop("after_dest");
    step(1'b0, 64'h0, 32'h0);
    chk_drop("gap");

    for (int k = 0; k < 9; k++) begin
      step(1'b1, 64'h2008 + 64'(4 * k), ADDI);
      chk_drop($sformatf("tdrop%0d", k));
    end
    chk("dropped12", {32'd0, dropped}, 64'd12);
    step(1'b1, 64'h202C, ADDI);
    chk_fwd("resync1", 64'h202C, ADDI, 3'b100);
    for (int k = 0; k < 10; k++) begin
      step(1'b1, 64'h2030 + 64'(4 * k), ADDI);
      chk_drop($sformatf("t2drop%0d", k));
    end
    step(1'b1, 64'h2058, ADDI);
    chk_fwd("resync2", 64'h2058, ADDI, 3'b100);
    chk("dropped22", {32'd0, dropped}, 64'd22);

    step(1'b1, 64'h3000, 32'h0000_A001);
    chk_fwd("c.j", 64'h3000, 32'h0000_A001, 3'b001);
    step(1'b1, 64'h3002, 32'h0000_E001);
    chk_fwd("c.bnez", 64'h3002, 32'h0000_E001, 3'b011);
    step(1'b1, 64'h3004, 32'h0000_8082);
    chk_fwd("c.jr", 64'h3004, 32'h0000_8082, 3'b011);
    step(1'b1, 64'h3006, 32'hFFFF_2001);
    chk_fwd("c.addiw", 64'h3006, 32'hFFFF_2001, 3'b010);
    step(1'b1, 64'h3008, 32'hABCD_808A);
    chk_drop("c.mv");
    chk("dropped23", {32'd0, dropped}, 64'd23);

    step(1'b1, 64'h4000, JAL);
    chk_fwd("jal", 64'h4000, JAL, 3'b001);
    step(1'b1, 64'h4100, JALR);
    chk_fwd("jalr", 64'h4100, JALR, 3'b011);
    step(1'b1, 64'h4200, ADDI);
    chk_fwd("jalr.dest", 64'h4200, ADDI, 3'b010);
    for (int k = 0; k < 10; k++) begin
      step(1'b1, 64'h4204 + 64'(4 * k), ADDI);
      chk_drop($sformatf("t3drop%0d", k));
    end
    step(1'b1, 64'h5000, BEQ);
    chk_fwd("expire_cf", 64'h5000, BEQ, 3'b101);
    step(1'b1, 64'h5004, ADDI);
    chk_fwd("expire_cf.dest", 64'h5004, ADDI, 3'b010);
    chk("dropped33", {32'd0, dropped}, 64'd33);

    step(1'b1, 64'h6000, BEQ);
    chk_fwd("pre_dis", 64'h6000, BEQ, 3'b001);
    en = 1'b0;
    step(1'b1, 64'h6004, ADDI);
    chk_drop("dis1");
    step(1'b1, 64'h6008, BEQ);
    chk_drop("dis2");
    chk("dis.dropped", {32'd0, dropped}, 64'd33);
    en = 1'b1;
    step(1'b0, 64'h0, 32'h0);
    chk_drop("reen.idle");
    step(1'b1, 64'h7000, ADDI);
    chk_fwd("reen", 64'h7000, ADDI, 3'b100);
    chk("reen.dropped", {32'd0, dropped}, 64'd33);

    step(1'b1, 64'h8000, BEQ);
    chk_fwd("pre_rst", 64'h8000, BEQ, 3'b001);
    rst_n = 1'b0;
    step(1'b1, 64'h8004, ADDI);
    chk("mrst.valid", {63'd0, bus.out_valid}, 64'd0);
    chk("mrst.pc", bus.out_pc, 64'd0);
    chk("mrst.instr", {32'd0, bus.out_instr}, 64'd0);
    chk("mrst.reason", {61'd0, bus.out_reason}, 64'd0);
    chk("mrst.dropped", {32'd0, dropped}, 64'd0);
    rst_n = 1'b1;
    step(1'b0, 64'h0, 32'h0);
    step(1'b1, 64'h9000, ADDI);
    chk_fwd("post_rst", 64'h9000, ADDI, 3'b100);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/trace_filter.md
Name: trace_filter

Overview:
- Sits directly upstream of the continuous monitoring system and reduces the retired-instruction stream to the items needed to reconstruct control flow.
- Forwards only these items:
  - the first instruction after enable;
  - every branch, jal or jalr (32-bit and compressed);
  - the instruction immediately after each of those, which proves the taken or not-taken destination;
  - one resync instruction whenever the resync timer expires.
- Output is registered.
- Item rate is at most one per cycle; there is no backpressure.

Parameters:
- XLEN, 64, PC width.
- RESYNC_TIMER_WIDTH, 8, width of the resync down-counter.
- RESYNC_TIMER_RESET_VALUE, 8'd10, number of consecutive dropped instructions that triggers a resync forward.

Ports:
- CLK  in  1  clock.
- RST_N  in  1  synchronous active-low reset.
- enable  in  1  filter active; low means nothing is forwarded.
- in_valid  in  1  a retired instruction is presented this cycle.
- in_pc  in  XLEN  PC of the retired instruction.
- in_instr  in  32  instruction bits; compressed instructions use [15:0] and ignore [31:16].
- out_valid  out  1  forwarded item valid, one-cycle pulse per item.
- out_pc  out  XLEN  registered copy of in_pc.
- out_instr  out  32  registered copy of in_instr.
- out_reason  out  3  [0] control-flow instruction, [1] destination of the previous control flow, [2] sync or resync.
- dropped_count  out  32  saturating count of valid instructions not forwarded while enabled.

Behaviour:
- Reset (RST_N=0 at a CLK edge): all outputs are 0, state=IDLE, timer=RESYNC_TIMER_RESET_VALUE, need_dest=0.
- Latency: an item accepted at edge N appears on out_* after edge N, valid for exactly one cycle. out_pc, out_instr and out_reason hold their last values when out_valid=0.
- Control-flow decode (cf), combinational on in_instr:
  - 32-bit forms, when in_instr[1:0]=2'b11 and opcode [6:0] is one of:
    - 7'b1100011 (branch)
    - 7'b1101111 (jal)
    - 7'b1100111 (jalr)
  - Compressed branch: [1:0]=2'b01 and [15:14]=2'b11 (c.beqz/c.bnez).
  - Compressed jump: [1:0]=2'b01 and [15:13]=3'b101 (c.j).
  - Compressed jr/jalr: [1:0]=2'b10, [15:13]=3'b100, [11:7]!=0, [6:2]=0.
  - [15:13]=3'b001 with quadrant 01 is c.addiw (RV64) and is not cf.
- States:
  - IDLE: entered when enable=0; out_valid=0; timer held at reset value; need_next=0. Goes to SYNC when enable=1.
  - SYNC: the first in_valid is forwarded with reason[2]=1, plus reason[0]=cf. Goes to RUN.
  - RUN: on each in_valid, forward = cf | need_dest | (timer==0).
    - reason = {timer==0, need_dest, cf}.
    - need_dest_next = cf.
    - On forward: timer reloads to RESYNC_TIMER_RESET_VALUE.
    - On drop: timer decrements and dropped_count increments, saturating at 32'hFFFFFFFF.
    - The timer never wraps below 0.
  - enable=0 in any state: next state IDLE. The in-flight output register still presents an item accepted on the previous edge. need_dest is lost; resync on re-enable covers it.
- in_valid=0: no state change and no timer decrement.
- Simultaneous cf, need_dest and timer expiry: one item with all applicable reason bits set; a single reload.
- Back-to-back control flow: each cf is forwarded. Every cf after the first carries reason=3'b011.
- dropped_count is cleared only by reset and is retained across enable toggles.
- Reset mid-stream: outputs return to 0 on the next edge; any pending need_dest is discarded.

Test Plan:
- Reset with enable=1, then 3 non-cf instructions (addi 32'h00000013) at PC 0x80000000, +4, +8 -> only the first forwarded, reason=3'b100, out_pc=0x80000000, one cycle latency; dropped_count=2.
- In RUN, beq (32'h00000063) at 0x1000, then addi at 0x2000 -> both forwarded, reasons 3'b001 then 3'b010; the following addi is dropped.
- 11 consecutive addi after a forward -> the first 10 are dropped; the 11th is forwarded with reason=3'b100; the timer reloads, and the next forward is due after 10 more drops.
- Compressed: c.j (16'hA001), c.bnez (16'hE001), c.jr x1 (16'h8082) are each forwarded with reason[0]=1. c.addiw (16'h2001) and c.mv x1,x2 (16'h808A) are not cf.
- jal immediately followed by jalr -> reasons 3'b001, 3'b011, and the next instruction 3'b010. Timer expiry coinciding with a cf -> reason 3'b101, a single item.
- Deassert enable while need_dest=1, then reassert -> nothing forwarded while disabled; the first instruction after re-enable gives reason 3'b100; dropped_count is unchanged while disabled. Assert RST_N=0 mid-stream -> all outputs 0 after the next edge.
